// File: rtl/weight_col_loader.sv
// rtl/weight_col_loader.sv - weight-load transmitter for one systolic-array column
// Reads one column of weights from SRAM and streams them into the top PE, deepest row first.
module weight_col_loader #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8,
  parameter int ADDR_WIDTH           = 10
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    start_ready,
  input  logic [ADDR_WIDTH-1:0]                   base_addr,
  output logic                                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                   mem_rd_addr,
  input  logic signed [DATA_WIDTH_IN-1:0]         mem_rd_data,
  output logic                                    wl_accept_w,
  output logic signed [DATA_WIDTH_IN-1:0]         wl_weight,
  output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] wl_index,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    switch_pending,
  input  logic                                    switch_ack
);

  localparam int IW = $clog2(SYSTOLIC_ARRAY_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(SYSTOLIC_ARRAY_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [IW-1:0]           cnt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    rd_pend;
  logic [IW-1:0]           rd_idx;
  logic                    start_acc;

  assign start_ready = (state == IDLE) && !switch_pending;
  assign start_acc   = start && start_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_acc) state_nx = READ;
      READ:    if (cnt == '0) state_nx = DRAIN;
      DRAIN:   if (cnt == IW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      base_q         <= '0;
      rd_pend        <= 1'b0;
      rd_idx         <= '0;
      mem_rd_en      <= 1'b0;
      mem_rd_addr    <= '0;
      wl_accept_w    <= 1'b0;
      wl_weight      <= '0;
      wl_index       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      switch_pending <= 1'b0;
    end else begin
      state <= state_nx;

      // cnt equals the row index of the read currently on the SRAM port
      rd_pend     <= mem_rd_en;
      rd_idx      <= mem_rd_en ? cnt : '0;
      wl_accept_w <= rd_pend;
      wl_weight   <= rd_pend ? mem_rd_data : '0;
      wl_index    <= rd_pend ? rd_idx : '0;

      case (state)
        IDLE: begin
          if (start_acc) begin
            base_q      <= base_addr;
            cnt         <= LAST;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= base_addr + ADDR_WIDTH'(LAST);
          end
        end
        READ: begin
          if (cnt == '0) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
          end else begin
            cnt         <= cnt - 1'b1;
            mem_rd_addr <= base_q + ADDR_WIDTH'(cnt - 1'b1);
          end
        end
        DRAIN:   cnt <= (cnt == '0) ? IW'(1) : '0;
        default: ;
      endcase

      busy <= (state_nx != IDLE);
      done <= (state == DRAIN) && (state_nx == DONE);

      if ((state == DRAIN) && (state_nx == DONE))
        switch_pending <= 1'b1;
      else if (switch_ack)
        switch_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_weight_col_loader.sv
// tb/tb_weight_col_loader.sv - self-checking bench for weight_col_loader
module tb_weight_col_loader;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int IW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 start_ready;
  logic [AW-1:0]        base_addr = '0;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_rd_addr;
  logic signed [DW-1:0] mem_rd_data = '0;
  logic                 wl_accept_w;
  logic signed [DW-1:0] wl_weight;
  logic [IW-1:0]        wl_index;
  logic                 busy;
  logic                 done;
  logic                 switch_pending;
  logic                 switch_ack = 1'b0;

  weight_col_loader #(
    .SYSTOLIC_ARRAY_WIDTH(N),
    .DATA_WIDTH_IN(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .wl_accept_w(wl_accept_w), .wl_weight(wl_weight),
    .wl_index(wl_index), .busy(busy), .done(done),
    .switch_pending(switch_pending), .switch_ack(switch_ack)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : '0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] w;
  } beat_t;

  logic [AW-1:0] exp_addr_q[$];
  beat_t         exp_beat_q[$];

  // scoreboard: every read address and beat is matched against the queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr_q.pop_front()));
      end else begin
        check("idle_rd_addr", 32'(mem_rd_addr), 0);
      end
      if (wl_accept_w) begin
        if (exp_beat_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          beat_t b;
          b = exp_beat_q.pop_front();
          check("beat_index", 32'(wl_index), 32'(b.idx));
          check("beat_weight", 32'(wl_weight), 32'(b.w));
        end
      end else begin
        check("idle_weight", 32'(wl_weight), 0);
        check("idle_index", 32'(wl_index), 0);
      end
    end
  end

  typedef struct {
    logic [AW-1:0]        base;
    int                   wbase;
    logic [AW-1:0]        exp_first_addr;
    logic [AW-1:0]        exp_last_addr;
    logic signed [DW-1:0] exp_w15;
    logic signed [DW-1:0] exp_w0;
  } vec_t;

  logic [AW-1:0]        first_addr, last_addr;
  logic signed [DW-1:0] w15, w0;

  // one load from E0 through N+5 cycles; optional abort when beat abort_idx appears
  task automatic do_load(input logic [AW-1:0] base, input int wbase, input logic hold,
                         input int abort_idx, output logic aborted);
    logic [AW-1:0] a;
    beat_t b;
    aborted = 1'b0;
    for (int r = 0; r < N; r++) mem[AW'(int'(base) + r)] = DW'(wbase + r);
    for (int k = 0; k < N; k++) begin
      a = AW'(int'(base) + N - 1 - k);
      exp_addr_q.push_back(a);
      b.idx = IW'(N - 1 - k);
      b.w   = mem[a];
      exp_beat_q.push_back(b);
    end
    @(negedge clk);
    check("start_ready_pre", 32'(start_ready), 1);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int t = 1; t <= N + 5; t++) begin
      @(negedge clk);
      check($sformatf("rd_en_t%0d", t), 32'(mem_rd_en), 32'(t >= 1 && t <= N));
      check($sformatf("accept_t%0d", t), 32'(wl_accept_w), 32'(t >= 3 && t <= N + 2));
      check($sformatf("done_t%0d", t), 32'(done), 32'(t == N + 3));
      check($sformatf("busy_t%0d", t), 32'(busy), 32'(t <= N + 3));
      if (t == 1) first_addr = mem_rd_addr;
      if (t == N) last_addr = mem_rd_addr;
      if (t == 3) w15 = wl_weight;
      if (t == N + 2) w0 = wl_weight;
      if (t == N + 3) check("pending_with_done", 32'(switch_pending), 1);
      if (abort_idx >= 0 && wl_accept_w && int'(wl_index) == abort_idx) begin
        aborted = 1'b1;
        return;
      end
    end
    check("addr_q_empty", 32'(exp_addr_q.size()), 0);
    check("beat_q_empty", 32'(exp_beat_q.size()), 0);
    check("pending_after_load", 32'(switch_pending), 1);
    check("ready_while_pending", 32'(start_ready), 0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    switch_ack = 1'b1;
    @(posedge clk);
    #1;
    switch_ack = 1'b0;
    check("pending_cleared", 32'(switch_pending), 0);
    check("ready_after_ack", 32'(start_ready), 1);
  endtask

  vec_t vecs[4];
  logic ab;

  initial begin
    vecs[0] = '{base: 10'h040, wbase: 1,    exp_first_addr: 10'h04F, exp_last_addr: 10'h040, exp_w15: 8'sd16,   exp_w0: 8'sd1};
    vecs[1] = '{base: 10'h3F8, wbase: -8,   exp_first_addr: 10'h007, exp_last_addr: 10'h3F8, exp_w15: 8'sd7,    exp_w0: -8'sd8};
    vecs[2] = '{base: 10'h000, wbase: 100,  exp_first_addr: 10'h00F, exp_last_addr: 10'h000, exp_w15: 8'sd115,  exp_w0: 8'sd100};
    vecs[3] = '{base: 10'h3F0, wbase: -128, exp_first_addr: 10'h3FF, exp_last_addr: 10'h3F0, exp_w15: -8'sd113, exp_w0: -8'sd128};

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_accept", 32'(wl_accept_w), 0);
    check("rst_pending", 32'(switch_pending), 0);
    check("rst_ready", 32'(start_ready), 1);

    for (int i = 0; i < 4; i++) begin
      do_load(vecs[i].base, vecs[i].wbase, 1'b0, -1, ab);
      check($sformatf("v%0d_first_addr", i), 32'(first_addr), 32'(vecs[i].exp_first_addr));
      check($sformatf("v%0d_last_addr", i), 32'(last_addr), 32'(vecs[i].exp_last_addr));
      check($sformatf("v%0d_w15", i), 32'(w15), 32'(vecs[i].exp_w15));
      check($sformatf("v%0d_w0", i), 32'(w0), 32'(vecs[i].exp_w0));
      if (i == 0) begin
        @(negedge clk);
        start = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("ignored_start_rd_en", 32'(mem_rd_en), 0);
          check("ignored_start_busy", 32'(busy), 0);
        end
        start = 1'b0;
      end
      do_ack();
    end

    // ack with nothing pending has no effect
    do_ack();
    @(negedge clk);
    check("noop_ack_busy", 32'(busy), 0);

    // start held high through a whole load gives exactly one load
    do_load(10'h100, 20, 1'b1, -1, ab);
    repeat (6) begin
      @(negedge clk);
      check("held_start_no_reload", 32'(mem_rd_en), 0);
    end
    start = 1'b0;
    do_ack();

    // ack and start together while pending: ack wins, start the cycle after is taken
    do_load(10'h200, -50, 1'b0, -1, ab);
    @(negedge clk);
    start      = 1'b1;
    switch_ack = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    switch_ack = 1'b0;
    check("simul_no_load", 32'(mem_rd_en), 0);
    check("simul_pending", 32'(switch_pending), 0);
    check("simul_ready", 32'(start_ready), 1);
    do_load(10'h210, 3, 1'b0, -1, ab);
    do_ack();

    // reset asserted during beat index 9
    do_load(10'h300, 40, 1'b0, 9, ab);
    check("abort_reached", 32'(ab), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_accept", 32'(wl_accept_w), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_en", 32'(mem_rd_en), 0);
    check("mid_rst_pending", 32'(switch_pending), 0);
    check("mid_rst_weight", 32'(wl_weight), 0);
    exp_addr_q.delete();
    exp_beat_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_ready", 32'(start_ready), 1);
    do_load(10'h300, 40, 1'b0, -1, ab);
    check("post_rst_w0", 32'(w0), 32'sd40);
    do_ack();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
